// File: rtl/ov7670_emul_if.sv
// Sensor-side signal bundle for the OV7670 emulator: control inputs plus the pclk/vsync/href/d bus.
// No handshake: href qualifies d, both are sampled at the rising edge of pclk and the receiver cannot stall.
interface ov7670_emul_if;
    logic        en;
    logic [1:0]  pattern;
    logic [11:0] solid_rgb;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic [2:0]  state_dbg;

    modport master (
        input  en, pattern, solid_rgb,
        output pclk, vsync, href, d, frame_done, frame_cnt, state_dbg
    );

    modport slave (
        output en, pattern, solid_rgb,
        input  pclk, vsync, href, d, frame_done, frame_cnt, state_dbg
    );
endinterface

// File: rtl/ov7670_emul.sv
// OV7670 camera emulator: generates RGB444 frames from an internal test pattern with sensor timing.
// All sync/data outputs move only on pclk falling edges so they are stable when the receiver samples.
module ov7670_emul #(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_hblank       = 16,
    parameter int c_vsync_lines  = 3,
    parameter int c_vback_lines  = 10,
    parameter int c_vfront_lines = 6
) (
    input  logic              clk,
    input  logic              rst,
    ov7670_emul_if.master     bus
);

    localparam int c_line     = 2 * c_img_cols + c_hblank;
    localparam int c_vs_ticks = c_vsync_lines * c_line;
    localparam int c_vb_ticks = c_vback_lines * c_line;
    localparam int c_vf_ticks = c_vfront_lines * c_line;
    localparam int c_cnt_w    = $clog2(c_line * (c_vsync_lines + c_vback_lines + c_vfront_lines) + 1);
    localparam int c_col_w    = (c_img_cols > 1) ? $clog2(c_img_cols) : 1;
    localparam int c_row_w    = (c_img_rows > 1) ? $clog2(c_img_rows) : 1;

    typedef logic [c_cnt_w-1:0] cnt_t;

    localparam cnt_t c_vs_last  = cnt_t'(c_vs_ticks - 1);
    localparam cnt_t c_vb_last  = cnt_t'(c_vb_ticks - 1);
    localparam cnt_t c_vf_last  = cnt_t'(c_vf_ticks - 1);
    localparam cnt_t c_act_last = cnt_t'(2 * c_img_cols - 1);
    localparam cnt_t c_hb_last  = cnt_t'(c_hblank - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(c_img_rows - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_HBLANK, ST_VFRONT
    } state_t;

    state_t               state_q, state_d;
    cnt_t                 cnt_q, cnt_d;
    logic [c_row_w-1:0]   row_q, row_d;
    logic [c_col_w-1:0]   col_q, col_d;
    logic                 phase_q, phase_d;
    logic                 pclk_q;
    logic                 vsync_q, vsync_d;
    logic                 href_q, href_d;
    logic [7:0]           d_q, d_d;
    logic [1:0]           pat_q, pat_d;
    logic [7:0]           frame_cnt_q, frame_cnt_d;
    logic                 frame_done_q, frame_done_d;

    // phase 0 carries {0,R}, phase 1 carries {G,B}
    function automatic logic [7:0] pix_byte(
        input logic [1:0]         pat,
        input logic [c_row_w-1:0] row,
        input logic [c_col_w-1:0] col,
        input logic               phase,
        input logic [11:0]        solid,
        input logic [3:0]         fcnt
    );
        logic [11:0] rgb;
        logic [2:0]  bar;
        bar = 3'(32'(col) / (c_img_cols / 8));
        case (pat)
            2'd0:    rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
            2'd1:    rgb = {4'(col), 4'(row), fcnt};
            2'd2:    rgb = solid;
            default: rgb = 12'(32'(row) * c_img_cols + 32'(col));
        endcase
        return phase ? rgb[7:0] : {4'h0, rgb[11:8]};
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        col_d        = col_q;
        phase_d      = phase_q;
        vsync_d      = vsync_q;
        href_d       = href_q;
        d_d          = d_q;
        pat_d        = pat_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        if (pclk_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en) begin
                        state_d = ST_VSYNC;
                        vsync_d = 1'b1;
                        cnt_d   = '0;
                        pat_d   = bus.pattern;
                    end
                end
                ST_VSYNC: begin
                    if (cnt_q == c_vs_last) begin
                        state_d = ST_VBACK;
                        vsync_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_VBACK: begin
                    if (cnt_q == c_vb_last) begin
                        state_d = ST_ACTIVE;
                        href_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                        phase_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q == c_act_last) begin
                        state_d = ST_HBLANK;
                        href_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        phase_d = ~phase_q;
                        if (phase_q) col_d = col_q + 1'b1;
                    end
                end
                ST_HBLANK: begin
                    if (cnt_q == c_hb_last) begin
                        cnt_d = '0;
                        if (row_q != c_row_last) begin
                            state_d = ST_ACTIVE;
                            row_d   = row_q + 1'b1;
                            href_d  = 1'b1;
                            col_d   = '0;
                            phase_d = 1'b0;
                        end else begin
                            state_d = ST_VFRONT;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_VFRONT: begin
                    if (cnt_q == c_vf_last) begin
                        cnt_d        = '0;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                        frame_done_d = 1'b1;
                        // en is only honoured here and in IDLE, so a frame never stops early
                        if (bus.en) begin
                            state_d = ST_VSYNC;
                            vsync_d = 1'b1;
                            pat_d   = bus.pattern;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            d_d = href_d ? pix_byte(pat_q, row_d, col_d, phase_d, bus.solid_rgb, frame_cnt_q[3:0])
                         : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            pclk_q       <= 1'b0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= 8'h00;
            pat_q        <= 2'd0;
            frame_cnt_q  <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            pclk_q       <= ~pclk_q;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            d_q          <= d_d;
            pat_q        <= pat_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pclk       = pclk_q;
    assign bus.vsync      = vsync_q;
    assign bus.href       = href_q;
    assign bus.d          = d_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_ov7670_emul.sv
// Self-checking bench for ov7670_emul: every pclk sample is compared with a stream model built
// from the frame layout (lines of L pclks, active bytes per pixel) and the four pattern formulas.
module tb_ov7670_emul;

    localparam int P_COLS  = 80;
    localparam int P_ROWS  = 8;
    localparam int P_HB    = 16;
    localparam int P_VS    = 3;
    localparam int P_VB    = 2;
    localparam int P_VF    = 2;
    localparam int L       = 2 * P_COLS + P_HB;
    localparam int FRAME   = (P_VS + P_VB + P_ROWS + P_VF) * L;
    localparam int BUDGET  = 3 * FRAME * 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ov7670_emul_if bus();

    ov7670_emul #(
        .c_img_cols     (P_COLS),
        .c_img_rows     (P_ROWS),
        .c_hblank       (P_HB),
        .c_vsync_lines  (P_VS),
        .c_vback_lines  (P_VB),
        .c_vfront_lines (P_VF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {vsync, href, d} expected in pclk period idx of a frame, counted from the first vsync period
    function automatic logic [9:0] exp_sample(input int idx, input int pat,
                                              input logic [11:0] solid, input int fcnt);
        int line, p, col, row, bar, a, r, g, b, byte_v;
        line = idx / L;
        p    = idx % L;
        if (line < P_VS) return {1'b1, 1'b0, 8'h00};
        row = line - P_VS - P_VB;
        if (row < 0 || row >= P_ROWS || p >= 2 * P_COLS) return 10'h000;
        col = p / 2;
        case (pat)
            0: begin
                bar = col / (P_COLS / 8);
                r = ((bar / 4) % 2 == 1) ? 15 : 0;
                g = ((bar / 2) % 2 == 1) ? 15 : 0;
                b = (bar % 2 == 1) ? 15 : 0;
            end
            1: begin
                r = col % 16;
                g = row % 16;
                b = fcnt % 16;
            end
            2: begin
                r = int'(solid[11:8]);
                g = int'(solid[7:4]);
                b = int'(solid[3:0]);
            end
            default: begin
                a = (row * P_COLS + col) % 4096;
                r = a / 256;
                g = (a / 16) % 16;
                b = a % 16;
            end
        endcase
        byte_v = (p % 2 == 0) ? r : g * 16 + b;
        return {1'b0, 1'b1, 8'(byte_v)};
    endfunction

    // Scoreboard: follows the pclk samples, frame boundaries and frame_done/frame_cnt
    int   sidx, fpat, mdl_fcnt, since_rst;
    logic in_frame, done_due, first_frame, nxt_pending, nxt_en;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame    = 1'b0;
            done_due    = 1'b0;
            first_frame = 1'b1;
            nxt_pending = 1'b0;
            nxt_en      = 1'b0;
            mdl_fcnt    = 0;
            since_rst   = 0;
            sidx        = 0;
            fpat        = 0;
        end else if (n_errors < 40) begin
            if (done_due || bus.frame_done) begin
                check("frame_done", 32'(bus.frame_done), 32'(done_due));
                if (done_due) begin
                    mdl_fcnt = (mdl_fcnt + 1) % 256;
                    check("frame_cnt", 32'(bus.frame_cnt), 32'(mdl_fcnt));
                    nxt_pending = 1'b1;
                    nxt_en      = bus.en;
                    done_due    = 1'b0;
                end
            end
            if (bus.pclk) begin
                if (!in_frame) begin
                    if (nxt_pending) begin
                        check("next_vsync", 32'(bus.vsync), 32'(nxt_en));
                        nxt_pending = 1'b0;
                    end
                    if (bus.vsync) begin
                        in_frame = 1'b1;
                        sidx     = 0;
                        fpat     = int'(bus.pattern);
                        if (first_frame) check("start_lat", 32'(since_rst), 32'd1);
                        first_frame = 1'b0;
                    end else begin
                        check("idle_bus", {23'd0, bus.href, bus.d}, 32'd0);
                    end
                end
                if (in_frame) begin
                    check($sformatf("stream@%0d", sidx), {22'd0, bus.vsync, bus.href, bus.d},
                          {22'd0, exp_sample(sidx, fpat, bus.solid_rgb, mdl_fcnt)});
                    sidx++;
                    if (sidx == FRAME) begin
                        in_frame = 1'b0;
                        done_due = 1'b1;
                    end
                end
                since_rst++;
            end
        end
    end

    task automatic wait_vsync(input logic lvl);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (bus.vsync === lvl) return;
        end
        check("timeout_vsync", 32'(bus.vsync), 32'(lvl));
    endtask

    task automatic wait_done();
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) return;
        end
        check("timeout_done", 32'(bus.frame_done), 32'd1);
    endtask

    int pats[4];

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b0;
        bus.en        = 1'b1;
        bus.pattern   = 2'd0;
        bus.solid_rgb = 12'($urandom);
        pats          = '{3, 1, 2, 0};
        pats[3]       = int'($urandom_range(0, 3));

        // reset with en high: everything held at zero, pclk static
        repeat (4) @(negedge clk);
        check("rst_pclk", 32'(bus.pclk), 32'd0);
        check("rst_vsync", 32'(bus.vsync), 32'd0);
        check("rst_href", 32'(bus.href), 32'd0);
        check("rst_d", 32'(bus.d), 32'd0);
        check("rst_done", 32'(bus.frame_done), 32'd0);
        check("rst_fcnt", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        check("rst_pclk_static", 32'(bus.pclk), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("pclk_toggle", 32'(bus.pclk), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // back-to-back frames; each frame picks the pattern for the one after it
        for (int f = 0; f < 4; f++) begin
            wait_vsync(1'b1);
            wait_vsync(1'b0);
            repeat (20) @(negedge clk);
            bus.pattern   = 2'(pats[f]);
            bus.solid_rgb = 12'($urandom);
            wait_done();
        end

        // drop en in the middle of row 4: frame must complete, then stay idle
        wait_vsync(1'b1);
        wait_vsync(1'b0);
        repeat ((P_VB * L + 4 * L + 10) * 2) @(negedge clk);
        bus.en = 1'b0;
        wait_done();
        repeat (4 * L * 2) @(negedge clk);
        check("idle_vsync", 32'(bus.vsync), 32'd0);
        check("idle_href", 32'(bus.href), 32'd0);
        check("idle_fcnt", 32'(bus.frame_cnt), 32'd5);

        // restart, then reset at row 5 col 40
        bus.en = 1'b1;
        wait_vsync(1'b1);
        wait_vsync(1'b0);
        repeat ((P_VB * L + 5 * L + 80) * 2) @(negedge clk);
        check("mid_href", 32'(bus.href), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_href", 32'(bus.href), 32'd0);
        check("abort_d", 32'(bus.d), 32'd0);
        check("abort_vsync", 32'(bus.vsync), 32'd0);
        check("abort_pclk", 32'(bus.pclk), 32'd0);
        check("abort_fcnt", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_done();
        check("restart_fcnt", 32'(bus.frame_cnt), 32'd1);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
